mult_accumulator: RTL and testbench

MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

---
 rtl/mult_acc_pkg.sv | 14 +
 rtl/acc_adder.sv | 32 +++
 rtl/mult_accumulator.sv | 115 +++++++++++
 tb/tb_mult_accumulator.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_acc_pkg.sv
// mult_acc_pkg: shared widths and FSM state encoding for mult_accumulator
// and its adder sub-module.
package mult_acc_pkg;

    localparam int PRODUCT_W = 8;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/acc_adder.sv
// acc_adder: ACC_W-bit accumulator adder with carry out.
// Configuration macro: MULT_ACC_SATURATE_EN -- when defined, a carry clamps
// the sum to all-ones; otherwise the sum wraps modulo 2^ACC_W.
// Ports:
//   acc    - current accumulator value
//   addend - unsigned product to add
//   sum    - wrapped or clamped result
//   carry  - carry out of ACC_W bits
module acc_adder
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0]     acc,
    input  logic [PRODUCT_W-1:0] addend,
    output logic [ACC_W-1:0]     sum,
    output logic                 carry
);

    logic [ACC_W:0] raw;

    assign raw   = {1'b0, acc} + {{(ACC_W + 1 - PRODUCT_W){1'b0}}, addend};
    assign carry = raw[ACC_W];

`ifdef MULT_ACC_SATURATE_EN
    // Once clamped, further additions carry again, so the value stays pinned.
    assign sum = carry ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
`else
    assign sum = raw[ACC_W-1:0];
`endif

endmodule

// File: rtl/mult_accumulator.sv
// mult_accumulator: sums BEATS unsigned 4x4 products into one frame sum with
// valid/ready handshakes on both sides and a sticky per-frame overflow flag.
// Configuration macro: MULT_ACC_SATURATE_EN (saturate instead of wrap; see
// acc_adder).
// Ports:
//   clk, rst             - clock, async active-high reset
//   clear                - synchronous frame abort, highest priority
//   in_valid/in_ready    - product beat handshake
//   product              - unsigned 8-bit product
//   out_valid/out_ready  - frame sum handshake
//   acc_out              - running / final sum
//   overflow             - sticky carry-out flag for this frame
//   beat_cnt             - beats accepted in this frame
//
// state | meaning
// IDLE  | no frame in progress, next beat starts a frame
// ACCUM | frame in progress, accumulating beats
// HOLD  | frame complete, sum presented until out_ready
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int ACC_W = 12,
    parameter int BEATS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PRODUCT_W-1:0] product,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_W-1:0]     acc_out,
    output logic                 overflow,
    output logic [CNT_W-1:0]     beat_cnt
);

    state_t           state, state_next;
    logic             beat;
    logic [ACC_W-1:0] sum;
    logic             carry;

    // Handshake outputs depend on state only, never on out_ready.
    assign in_ready  = (state != HOLD);
    assign out_valid = (state == HOLD);
    assign beat      = in_valid && in_ready;

    acc_adder #(.ACC_W(ACC_W)) u_adder (
        .acc    (acc_out),
        .addend (product),
        .sum    (sum),
        .carry  (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (beat) state_next = ACCUM;
                ACCUM:   if (beat && beat_cnt == CNT_W'(BEATS - 1)) state_next = HOLD;
                HOLD:    if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out  <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            acc_out  <= '0;
            beat_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (beat) begin
                        acc_out  <= ACC_W'(product);
                        beat_cnt <= CNT_W'(1);
                        overflow <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc_out  <= sum;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                        overflow <= overflow | carry;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_out  <= '0;
                        beat_cnt <= '0;
                        overflow <= 1'b0;
                    end
                end
                default: begin
                    acc_out  <= '0;
                    beat_cnt <= '0;
                    overflow <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator: directed bench for mult_accumulator. Two instances
// share all stimulus: u_dut12 (defaults) and u_dut10 (ACC_W = 10) so wrap /
// saturation can be seen alongside the non-overflowing default width.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_mult_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [7:0]  product;
    logic        out_ready;

    logic        in_ready12, out_valid12, overflow12;
    logic [11:0] acc12;
    logic [3:0]  cnt12;
    logic        in_ready10, out_valid10, overflow10;
    logic [9:0]  acc10;
    logic [3:0]  cnt10;

    int total = 0;
    int bad   = 0;
    bit sat_en;

    typedef struct {
        logic [31:0] acc12;
        logic        ovf12;
        logic [31:0] acc10;
        logic        ovf10;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mult_accumulator u_dut12 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready12), .product(product), .out_valid(out_valid12),
        .out_ready(out_ready), .acc_out(acc12), .overflow(overflow12),
        .beat_cnt(cnt12)
    );

    mult_accumulator #(.ACC_W(10), .BEATS(8)) u_dut10 (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid),
        .in_ready(in_ready10), .product(product), .out_valid(out_valid10),
        .out_ready(out_ready), .acc_out(acc10), .overflow(overflow10),
        .beat_cnt(cnt10)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference model of one frame at a given width.
    task automatic model(input logic [7:0] p [8], input int w,
                         output logic [31:0] acc, output logic ovf);
        int s;
        int lim;
        lim = 1 << w;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s = int'(acc) + int'(p[i]);
            if (s >= lim) begin
                ovf = 1'b1;
                s   = sat_en ? lim - 1 : s - lim;
            end
            acc = s;
        end
    endtask

    task automatic one_beat(input logic [7:0] p, input int gap);
        in_valid = 1'b1;
        product  = p;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    // Pushes the expected result, then drives the frame. Returns on the
    // falling edge right after the last accepting rising edge.
    task automatic frame(input logic [7:0] p [8], input int gap);
        exp_t e;
        model(p, 12, e.acc12, e.ovf12);
        model(p, 10, e.acc10, e.ovf10);
        sb.push_back(e);
        for (int i = 0; i < 8; i++) one_beat(p[i], (i == 7) ? 0 : gap);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        chk({tag, "_valid_latency"}, 32'(out_valid12), 32'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_acc12"}, 32'(acc12), e.acc12);
            chk({tag, "_ovf12"}, 32'(overflow12), 32'(e.ovf12));
            chk({tag, "_acc10"}, 32'(acc10), e.acc10);
            chk({tag, "_ovf10"}, 32'(overflow10), 32'(e.ovf10));
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid12), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready12), 32'd1);
        chk({tag, "_acc"}, 32'(acc12), 32'd0);
        chk({tag, "_cnt"}, 32'(cnt12), 32'd0);
        chk({tag, "_ovf"}, 32'(overflow12), 32'd0);
    endtask

    logic [7:0] f [8];

    initial begin
`ifdef MULT_ACC_SATURATE_EN
        sat_en = 1'b1;
`else
        sat_en = 1'b0;
`endif
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        product   = '0;
        out_ready = 1'b1;
        #3;
        check_idle("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back 8 x 30.
        f = '{30, 30, 30, 30, 30, 30, 30, 30};
        for (int i = 0; i < 3; i++) one_beat(f[i], 0);
        chk("partial_cnt", 32'(cnt12), 32'd3);
        chk("partial_acc", 32'(acc12), 32'd90);
        chk("partial_in_ready", 32'(in_ready12), 32'd1);
        // Remaining 5 beats plus scoreboard entry for the whole frame.
        begin
            exp_t e;
            model(f, 12, e.acc12, e.ovf12);
            model(f, 10, e.acc10, e.ovf10);
            sb.push_back(e);
        end
        for (int i = 3; i < 8; i++) one_beat(f[i], 0);
        check_result("b2b30");
        @(negedge clk);
        check_idle("b2b30_after");

        // Gapped frame, consumer stalls 5 cycles; beats offered during HOLD
        // must be ignored.
        out_ready = 1'b0;
        f = '{60, 36, 75, 225, 0, 1, 2, 3};
        frame(f, 2);
        check_result("gap");
        in_valid = 1'b1;
        product  = 8'd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_acc", 32'(acc12), 32'd402);
            chk("hold_in_ready", 32'(in_ready12), 32'd0);
            chk("hold_valid", 32'(out_valid12), 32'd1);
        end
        chk("hold_cnt", 32'(cnt12), 32'd8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_idle("gap_after");

        // Overflow: 8 x 225 (1800) fits 12 bits but not 10.
        f = '{225, 225, 225, 225, 225, 225, 225, 225};
        frame(f, 0);
        check_result("ovf");
        chk("ovf10_value", 32'(acc10), sat_en ? 32'd1023 : 32'd776);
        chk("ovf10_flag", 32'(overflow10), 32'd1);
        @(negedge clk);
        chk("ovf10_cleared", 32'(overflow10), 32'd0);
        check_idle("ovf_after");

        // Clear together with the 4th beat of 50.
        for (int i = 0; i < 3; i++) one_beat(8'd50, 0);
        chk("pre_clear_acc", 32'(acc12), 32'd150);
        in_valid = 1'b1;
        product  = 8'd50;
        clear    = 1'b1;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        check_idle("clear");
        f = '{50, 50, 50, 50, 50, 50, 50, 50};
        frame(f, 0);
        check_result("after_clear");
        @(negedge clk);

        // Asynchronous reset mid-frame, between clock edges.
        for (int i = 0; i < 3; i++) one_beat(8'd12, 0);
        chk("pre_rst_acc", 32'(acc12), 32'd36);
        #2;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        chk("async_rst_acc10", 32'(acc10), 32'd0);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_cnt", 32'(cnt12), 32'd0);
        f = '{12, 12, 12, 12, 12, 12, 12, 12};
        frame(f, 0);
        check_result("after_rst");
        @(negedge clk);
        check_idle("final");
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
